// File: rtl/uart_data_reader_if.sv
// Bus between the memory-to-UART reader, the sample memory read port and the
// UART transmitter handshake.
interface uart_data_reader_if #(
   parameter int ADDR_WIDTH = 16
);
   logic                  Ren;
   logic [ADDR_WIDTH-1:0] Addr;
   logic [7:0]            Din;
   logic [7:0]            Tx_data;
   logic                  Tx_start;
   logic                  Tx_done;

   // The reader drives the memory read request and the transmitter byte
   modport master (
      output Ren, Addr, Tx_data, Tx_start,
      input  Din, Tx_done
   );

   // Memory and transmitter side
   modport slave (
      input  Ren, Addr, Tx_data, Tx_start,
      output Din, Tx_done
   );
endinterface

// File: rtl/uart_data_reader.sv
// Streams sample memory addresses 0..LAST_ADDR to the UART transmitter, one
// byte per Tx_start/Tx_done handshake, and raises fin after the last byte.
// All outputs are registered; each one is loaded from the next state so it is
// valid in the same cycle the FSM enters the matching state.
module uart_data_reader #(
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] LAST_ADDR  = 16'hFFFF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               fin,
   uart_data_reader_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT_MEM,
      S_LOAD,
      S_SEND,
      S_WAIT_TX,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic                  ren_q, ren_d;
   logic                  tx_start_q, tx_start_d;
   logic                  fin_q, fin_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            tx_data_q, tx_data_d;

   logic                  last_byte;

   assign last_byte = (addr_q == LAST_ADDR);

   // State and output registers; reset aborts any byte in flight at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ren_q      <= 1'b0;
         tx_start_q <= 1'b0;
         fin_q      <= 1'b0;
         addr_q     <= '0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         ren_q      <= ren_d;
         tx_start_q <= tx_start_d;
         fin_q      <= fin_d;
         addr_q     <= addr_d;
         tx_data_q  <= tx_data_d;
      end
   end

   // Next-state: fixed read/load/send sequence, then wait on the transmitter
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (start) state_d = S_READ;
         S_READ:     state_d = S_WAIT_MEM;
         S_WAIT_MEM: state_d = S_LOAD;
         S_LOAD:     state_d = S_SEND;
         S_SEND:     state_d = S_WAIT_TX;
         S_WAIT_TX:  if (bus.Tx_done) state_d = last_byte ? S_DONE : S_READ;
         S_DONE:     if (start) state_d = S_READ;
         default:    state_d = S_IDLE;
      endcase
   end

   // Output/datapath next values; strobes decode the state being entered
   always_comb begin
      ren_d      = (state_d == S_READ);
      tx_start_d = (state_d == S_SEND);
      fin_d      = (state_d == S_DONE);
      addr_d     = addr_q;
      tx_data_d  = tx_data_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) addr_d = '0;
         end
         S_WAIT_MEM: begin
            tx_data_d = bus.Din;
         end
         S_WAIT_TX: begin
            // Increment only below LAST_ADDR, so Addr can never wrap
            if (bus.Tx_done && !last_byte) addr_d = addr_q + ADDR_WIDTH'(1);
         end
         default: begin
         end
      endcase
   end

   assign bus.Ren      = ren_q;
   assign bus.Addr     = addr_q;
   assign bus.Tx_data  = tx_data_q;
   assign bus.Tx_start = tx_start_q;
   assign fin          = fin_q;

endmodule

// File: tb/tb_uart_data_reader.sv
module tb_uart_data_reader;
   localparam int AW     = 16;
   localparam int LAST_A = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic startA = 1'b0, startB = 1'b0;
   logic finA, finB;
   logic inj_done = 1'b0;
   logic doneB = 1'b0;
   logic tx_done_m = 1'b0;
   int   tx_cnt = 0;
   int   tx_delay = 10;
   logic [7:0] mem [4];

   int nvec = 0;
   int nerr = 0;

   uart_data_reader_if #(.ADDR_WIDTH(AW)) busA ();
   uart_data_reader_if #(.ADDR_WIDTH(AW)) busB ();

   uart_data_reader #(.ADDR_WIDTH(AW), .LAST_ADDR(16'd3)) dutA (
      .clk(clk), .rst(rst), .start(startA), .fin(finA), .bus(busA.master));
   uart_data_reader #(.ADDR_WIDTH(AW), .LAST_ADDR(16'd0)) dutB (
      .clk(clk), .rst(rst), .start(startB), .fin(finB), .bus(busB.master));

   always #5 clk = ~clk;

   // Memory models: one cycle read latency
   always @(posedge clk) if (busA.Ren) busA.Din <= mem[busA.Addr[1:0]];
   always @(posedge clk) if (busB.Ren) busB.Din <= mem[busB.Addr[1:0]];

   assign busA.Tx_done = tx_done_m | inj_done;
   assign busB.Tx_done = doneB;

   // Transmitter model: Tx_done high tx_delay cycles after the Tx_start cycle
   always @(posedge clk) begin
      tx_done_m <= 1'b0;
      if (busA.Tx_start) tx_cnt <= tx_delay - 1;
      else if (tx_cnt > 0) begin
         tx_cnt <= tx_cnt - 1;
         if (tx_cnt == 1) tx_done_m <= 1'b1;
      end
   end

   // Event log: edge indices of sampled inputs, interval indices of outputs
   int ecnt = 0;
   int start_e[$], done_e[$], ren_i[$], ts_i[$], bytes_q[$], addrs_q[$];
   int fin_q[$], ren_busy[$];
   logic fin_prev = 1'b0;

   always @(posedge clk) begin
      ecnt <= ecnt + 1;
      if (!rst && startA)    start_e.push_back(ecnt + 1);
      if (!rst && tx_done_m) done_e.push_back(ecnt + 1);
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (busA.Ren) ren_i.push_back(ecnt);
         if (busA.Tx_start) begin
            ts_i.push_back(ecnt);
            bytes_q.push_back(int'(busA.Tx_data));
            addrs_q.push_back(int'(busA.Addr));
         end
         if (busA.Ren && (tx_cnt != 0 || tx_done_m)) ren_busy.push_back(ecnt);
         if (finA && !fin_prev) fin_q.push_back(ecnt);
      end
      fin_prev <= finA;
   end

   function automatic int qget(input int q[$], input int i);
      return (i >= 0 && i < q.size()) ? q[i] : -9999;
   endfunction

   task automatic clear_mon();
      start_e.delete(); done_e.delete(); ren_i.delete(); ts_i.delete();
      bytes_q.delete(); addrs_q.delete(); fin_q.delete(); ren_busy.delete();
   endtask

   task automatic set_hello();
      mem[0] = 8'h68; mem[1] = 8'h65; mem[2] = 8'h6C; mem[3] = 8'h6F;
   endtask

   task automatic do_transfer(input int maxcyc, output bit timed_out);
      @(negedge clk); startA = 1'b1;
      @(negedge clk); startA = 1'b0;
      timed_out = 1'b1;
      for (int c = 0; c < maxcyc; c++) begin
         @(negedge clk);
         if (finA) begin timed_out = 1'b0; break; end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      nvec++;
      if ({busA.Ren, busA.Addr, busA.Tx_data, busA.Tx_start, finA,
           busB.Ren, busB.Addr, busB.Tx_data, busB.Tx_start, finB} !== 54'd0) begin
         nerr++; $display("FAIL reset_in: outputs not all 0 during reset");
      end
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         nvec++;
         if ({busA.Ren, busA.Addr, busA.Tx_data, busA.Tx_start, finA} !== 27'd0) begin
            nerr++; $display("FAIL reset_idle: got %h required 0",
                             {busA.Ren, busA.Addr, busA.Tx_data, busA.Tx_start, finA});
         end
      end
      @(posedge clk); #3 rst = 1'b1; #1;
      nvec++;
      if ({busA.Ren, busA.Addr, busA.Tx_data, busA.Tx_start, finA} !== 27'd0) begin
         nerr++; $display("FAIL reset_async: outputs not 0 after async reset");
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_basic();
      bit to;
      int lat;
      set_hello(); tx_delay = 10; clear_mon();
      do_transfer(400, to);
      repeat (5) @(negedge clk);
      nvec++;
      if (to) begin nerr++; $display("FAIL basic_timeout: fin=0 after 400 cycles, required 1"); end
      nvec++;
      if (ts_i.size() != LAST_A + 1) begin
         nerr++; $display("FAIL basic_count: %0d Tx_start pulses, required %0d", ts_i.size(), LAST_A + 1);
      end
      for (int k = 0; k <= LAST_A; k++) begin
         nvec++;
         if (qget(bytes_q, k) != int'(mem[k]) || qget(addrs_q, k) != k) begin
            nerr++; $display("FAIL basic_byte[%0d]: data %0h addr %0d, required %0h addr %0d",
                             k, qget(bytes_q, k), qget(addrs_q, k), mem[k], k);
         end
      end
      lat = qget(ts_i, 0) - qget(start_e, 0);
      nvec++;
      if (lat != 3) begin nerr++; $display("FAIL basic_first_lat: %0d cycles, required 3", lat); end
      for (int k = 1; k <= LAST_A; k++) begin
         nvec++;
         if (qget(ren_i, k) != qget(done_e, k - 1) || qget(ts_i, k) != qget(done_e, k - 1) + 3) begin
            nerr++; $display("FAIL basic_gap[%0d]: ren %0d ts %0d, required ren %0d ts %0d", k,
                             qget(ren_i, k), qget(ts_i, k), qget(done_e, k - 1), qget(done_e, k - 1) + 3);
         end
      end
      nvec++;
      if (fin_q.size() != 1 || qget(fin_q, 0) != qget(done_e, LAST_A)) begin
         nerr++; $display("FAIL basic_fin: rise at %0d, required %0d", qget(fin_q, 0), qget(done_e, LAST_A));
      end
      nvec++;
      if (ren_busy.size() != 0) begin
         nerr++; $display("FAIL basic_ren_wait: Ren high %0d times in WAIT_TX, required 0", ren_busy.size());
      end
   endtask

   task automatic test_restart();
      bit to;
      nvec++;
      if (finA !== 1'b1 || busA.Addr !== 16'd3) begin
         nerr++; $display("FAIL restart_done: fin %b addr %0d, required fin 1 addr 3", finA, busA.Addr);
      end
      clear_mon();
      @(negedge clk); startA = 1'b1;
      @(negedge clk); startA = 1'b0;
      nvec++;
      if ({finA, busA.Addr, busA.Ren} !== {1'b0, 16'd0, 1'b1}) begin
         nerr++; $display("FAIL restart_go: fin %b addr %0d ren %b, required 0 0 1", finA, busA.Addr, busA.Ren);
      end
      to = 1'b1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (finA) begin to = 1'b0; break; end
      end
      #1;
      nvec++;
      if (to || ts_i.size() != LAST_A + 1) begin
         nerr++; $display("FAIL restart_count: timeout %b pulses %0d, required 0 and 4", to, ts_i.size());
      end
      for (int k = 0; k <= LAST_A; k++) begin
         nvec++;
         if (qget(bytes_q, k) != int'(mem[k]) || qget(addrs_q, k) != k) begin
            nerr++; $display("FAIL restart_byte[%0d]: data %0h addr %0d, required %0h addr %0d",
                             k, qget(bytes_q, k), qget(addrs_q, k), mem[k], k);
         end
      end
   endtask

   task automatic test_spurious();
      bit to;
      clear_mon(); set_hello(); tx_delay = 10;
      fork
         do_transfer(400, to);
         begin
            bit r1 = 1'b0, r2 = 1'b0, did = 1'b0, clr = 1'b0;
            repeat (2) @(negedge clk);
            for (int c = 0; c < 400; c++) begin
               @(negedge clk);
               if (finA) break;
               inj_done = busA.Ren | r2 | busA.Tx_start;
               r2 = r1; r1 = busA.Ren;
               if (!did && tx_cnt > 3) begin startA = 1'b1; did = 1'b1; clr = 1'b1; end
               else if (clr) begin startA = 1'b0; clr = 1'b0; end
            end
            inj_done = 1'b0;
         end
      join
      startA = 1'b0;
      repeat (3) @(negedge clk);
      nvec++;
      if (to || ts_i.size() != LAST_A + 1) begin
         nerr++; $display("FAIL spur_count: timeout %b pulses %0d, required 0 and 4", to, ts_i.size());
      end
      for (int k = 0; k <= LAST_A; k++) begin
         nvec++;
         if (qget(bytes_q, k) != int'(mem[k]) || qget(addrs_q, k) != k) begin
            nerr++; $display("FAIL spur_byte[%0d]: data %0h addr %0d, required %0h addr %0d",
                             k, qget(bytes_q, k), qget(addrs_q, k), mem[k], k);
         end
      end
      for (int k = 1; k <= LAST_A; k++) begin
         nvec++;
         if (qget(ts_i, k) != qget(done_e, k - 1) + 3) begin
            nerr++; $display("FAIL spur_gap[%0d]: ts %0d, required %0d", k, qget(ts_i, k), qget(done_e, k - 1) + 3);
         end
      end
      nvec++;
      if (qget(fin_q, 0) != qget(done_e, LAST_A)) begin
         nerr++; $display("FAIL spur_fin: rise at %0d, required %0d", qget(fin_q, 0), qget(done_e, LAST_A));
      end
   endtask

   task automatic test_random();
      bit to;
      int lat;
      for (int it = 0; it < 4; it++) begin
         for (int i = 0; i < 4; i++) mem[i] = 8'($urandom_range(0, 255));
         tx_delay = $urandom_range(2, 25);
         clear_mon();
         do_transfer(600, to);
         repeat (3) @(negedge clk);
         nvec++;
         if (to || ts_i.size() != LAST_A + 1) begin
            nerr++; $display("FAIL rand%0d_count: timeout %b pulses %0d, required 0 and 4", it, to, ts_i.size());
         end
         for (int k = 0; k <= LAST_A; k++) begin
            nvec++;
            if (qget(bytes_q, k) != int'(mem[k]) || qget(addrs_q, k) != k) begin
               nerr++; $display("FAIL rand%0d_byte[%0d]: data %0h addr %0d, required %0h addr %0d",
                                it, k, qget(bytes_q, k), qget(addrs_q, k), mem[k], k);
            end
         end
         lat = qget(ts_i, 0) - qget(start_e, 0);
         nvec++;
         if (lat != 3) begin nerr++; $display("FAIL rand%0d_first_lat: %0d, required 3", it, lat); end
         for (int k = 1; k <= LAST_A; k++) begin
            nvec++;
            if (qget(ren_i, k) != qget(done_e, k - 1) || qget(ts_i, k) != qget(done_e, k - 1) + 3) begin
               nerr++; $display("FAIL rand%0d_gap[%0d]: ren %0d ts %0d, required %0d %0d", it, k,
                                qget(ren_i, k), qget(ts_i, k), qget(done_e, k - 1), qget(done_e, k - 1) + 3);
            end
         end
         nvec++;
         if (qget(fin_q, 0) != qget(done_e, LAST_A) || ren_busy.size() != 0) begin
            nerr++; $display("FAIL rand%0d_fin: rise %0d ren_busy %0d, required %0d and 0", it,
                             qget(fin_q, 0), ren_busy.size(), qget(done_e, LAST_A));
         end
      end
   endtask

   task automatic test_last_zero();
      int n = 0, done_it = -1, fin_it = -1, pend = 0;
      int got = -1;
      mem[0] = 8'($urandom_range(1, 255));
      @(negedge clk); startB = 1'b1;
      @(negedge clk); startB = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         doneB = 1'b0;
         if (finB && fin_it < 0) fin_it = c;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin doneB = 1'b1; done_it = c; end
         end
         if (busB.Tx_start) begin n++; got = int'(busB.Tx_data); pend = 6; end
      end
      doneB = 1'b0;
      nvec++;
      if (n != 1 || got != int'(mem[0])) begin
         nerr++; $display("FAIL zero_bytes: %0d pulses data %0h, required 1 and %0h", n, got, mem[0]);
      end
      nvec++;
      if (fin_it != done_it + 1 || finB !== 1'b1 || busB.Addr !== 16'd0) begin
         nerr++; $display("FAIL zero_fin: fin at %0d fin %b addr %0d, required %0d 1 0",
                          fin_it, finB, busB.Addr, done_it + 1);
      end
   endtask

   task automatic test_reset_mid();
      bit to;
      int n = 0, act = 0;
      set_hello(); tx_delay = 10; clear_mon();
      @(negedge clk); startA = 1'b1;
      @(negedge clk); startA = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (busA.Tx_start) n++;
         if (n == 2) break;
      end
      repeat (3) @(negedge clk);
      nvec++;
      if (busA.Tx_data !== 8'h65 || busA.Addr !== 16'd1) begin
         nerr++; $display("FAIL mid_pre: data %0h addr %0d, required 65 1", busA.Tx_data, busA.Addr);
      end
      #2 rst = 1'b1; #1;
      nvec++;
      if ({busA.Ren, busA.Addr, busA.Tx_data, busA.Tx_start, finA} !== 27'd0) begin
         nerr++; $display("FAIL mid_reset: got %h required 0",
                          {busA.Ren, busA.Addr, busA.Tx_data, busA.Tx_start, finA});
      end
      @(negedge clk); rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (busA.Ren || busA.Tx_start || finA) act++;
      end
      nvec++;
      if (act != 0) begin nerr++; $display("FAIL mid_ignore: %0d active cycles after reset, required 0", act); end
      clear_mon();
      do_transfer(400, to);
      nvec++;
      if (to || ts_i.size() != LAST_A + 1) begin
         nerr++; $display("FAIL mid_resend_count: timeout %b pulses %0d, required 0 and 4", to, ts_i.size());
      end
      for (int k = 0; k <= LAST_A; k++) begin
         nvec++;
         if (qget(bytes_q, k) != int'(mem[k]) || qget(addrs_q, k) != k) begin
            nerr++; $display("FAIL mid_resend[%0d]: data %0h addr %0d, required %0h addr %0d",
                             k, qget(bytes_q, k), qget(addrs_q, k), mem[k], k);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_restart();
      test_spurious();
      test_random();
      test_last_zero();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
